// File: rtl/led_breathe_driver_pkg.sv
// Shared definitions for the LED breathing driver: FSM state encoding and brightness curve.
// Define LED_BREATHE_GAMMA_EN to select the square-law eff() curve; otherwise eff() is linear.
package led_breathe_driver_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    // Maps a linear brightness level to a PWM duty; bits is the PWM resolution.
    function automatic logic [31:0] eff(input logic [31:0] level, input int unsigned bits);
`ifdef LED_BREATHE_GAMMA_EN
        logic [63:0] sq;
        sq = 64'(level) * 64'(level);
        if (level == ((32'd1 << bits) - 32'd1))
            return level;
        return 32'(sq >> bits);
`else
        return level & ((32'd1 << bits) - 32'd1);
`endif
    endfunction

endpackage

// File: rtl/led_pwm_core.sv
// PWM engine: free-running period counter, wrap strobe, per-period duty latch and registered LED compare.
// Curve selection (LED_BREATHE_GAMMA_EN) happens upstream; this block only sees the effective duty.
module led_pwm_core #(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_en,
    input  logic [PWM_BITS-1:0] eff_level,
    output logic                wrap,
    output logic                o_led
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;

    assign wrap = (pwm_cnt == MAX);

    // Duty only updates on the last count of a period so a period is never split.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            pwm_cnt <= '0;
            duty    <= '0;
            o_led   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (wrap)
                duty <= eff_level;
            o_led <= i_en && ((duty == MAX) || (pwm_cnt < duty));
        end
    end

endmodule

// File: rtl/led_breathe_driver.sv
// Fades the LED linearly up while i_led is high and down while low, driving o_led through PWM.
// Optional square-law brightness curve: define LED_BREATHE_GAMMA_EN.
module led_breathe_driver
    import led_breathe_driver_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 16
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_led,
    input  logic                i_en,
    output logic                o_led,
    output logic                o_busy,
    output logic [PWM_BITS-1:0] o_level
);

    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam int                  SC_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [SC_W-1:0]     SC_LAST = SC_W'(STEP_PERIODS - 1);

    state_t              state, state_nxt;
    logic [PWM_BITS-1:0] level, level_nxt;
    logic [SC_W-1:0]     step_cnt;
    logic [PWM_BITS-1:0] eff_level;
    logic                wrap;
    logic                tick;

    function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] v);
        return (v == MAX) ? MAX : v + 1'b1;
    endfunction

    function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign tick = wrap && (step_cnt == SC_LAST);

    // Step counter free-runs across state changes so ramp phase is independent of input timing.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            step_cnt <= '0;
        else if (wrap)
            step_cnt <= (step_cnt == SC_LAST) ? '0 : step_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state <= ST_OFF;
            level <= '0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
        end
    end

    // A direction change takes priority over a coincident step, so the level holds that edge.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        if (!i_en) begin
            state_nxt = ST_OFF;
            level_nxt = '0;
        end else begin
            case (state)
                ST_OFF:  if (i_led) state_nxt = ST_UP;
                ST_UP: begin
                    if (!i_led) begin
                        state_nxt = ST_DOWN;
                    end else if (tick) begin
                        level_nxt = sat_inc(level);
                        if (level_nxt == MAX)
                            state_nxt = ST_ON;
                    end
                end
                ST_ON:   if (!i_led) state_nxt = ST_DOWN;
                ST_DOWN: begin
                    if (i_led) begin
                        state_nxt = ST_UP;
                    end else if (tick) begin
                        level_nxt = sat_dec(level);
                        if (level_nxt == '0)
                            state_nxt = ST_OFF;
                    end
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    assign eff_level = PWM_BITS'(eff(32'(level), PWM_BITS));
    assign o_busy    = (state == ST_UP) || (state == ST_DOWN);
    assign o_level   = level;

    led_pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_core (
        .i_clk     (i_clk),
        .i_resetn  (i_resetn),
        .i_en      (i_en),
        .eff_level (eff_level),
        .wrap      (wrap),
        .o_led     (o_led)
    );

endmodule

// File: tb/tb_led_breathe_driver.sv
// Scoreboard bench for led_breathe_driver (PWM_BITS=4, STEP_PERIODS=2) with a cycle-level reference model.
module tb_led_breathe_driver;

    localparam int PB   = 4;
    localparam int SP   = 2;
    localparam int MAXL = 15;
    localparam int PER  = 16;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       led    = 1'b0;
    logic       en     = 1'b0;
    logic       o_led;
    logic       o_busy;
    logic [3:0] o_level;

    led_breathe_driver #(
        .PWM_BITS     (PB),
        .STEP_PERIODS (SP)
    ) dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_led    (led),
        .i_en     (en),
        .o_led    (o_led),
        .o_busy   (o_busy),
        .o_level  (o_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int led;
        int busy;
        int level;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: target direction, whether the fade has settled, level, latched duty, edge count.
    int m_level, m_dir, m_settled, m_duty, m_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_eff(input int l);
`ifdef LED_BREATHE_GAMMA_EN
        if (l == MAXL) return MAXL;
        return (l * l) / PER;
`else
        return l;
`endif
    endfunction

    task automatic model_reset();
        m_level   = 0;
        m_dir     = 0;
        m_settled = 1;
        m_duty    = 0;
        m_cnt     = 0;
    endtask

    // Advance the model by one edge using the current inputs, clock the DUT, queue the expectation.
    task automatic cycle();
        exp_t e;
        int   phase;
        bit   tick;
        int   nled;
        phase = m_cnt % PER;
        tick  = ((m_cnt % (PER * SP)) == PER * SP - 1);
        nled  = (en && (m_duty == MAXL || phase < m_duty)) ? 1 : 0;
        if (phase == PER - 1)
            m_duty = ref_eff(m_level);
        if (!en) begin
            m_level   = 0;
            m_dir     = 0;
            m_settled = 1;
        end else if (int'(led) != m_dir) begin
            m_dir     = int'(led);
            m_settled = 0;
        end else if (!m_settled && tick) begin
            if (m_dir == 1) m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
            else            m_level = (m_level > 0) ? m_level - 1 : 0;
            if (m_level == (m_dir == 1 ? MAXL : 0))
                m_settled = 1;
        end
        m_cnt++;
        @(posedge clk);
        #1;
        e.led   = nled;
        e.busy  = m_settled ? 0 : 1;
        e.level = m_level;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_o_led",   int'(o_led),   e.led);
            chk("sb_o_busy",  int'(o_busy),  e.busy);
            chk("sb_o_level", int'(o_level), e.level);
        end
    end

    task automatic wait_level(input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (int'(o_level) != target && k < budget) begin
            cycle();
            k++;
        end
        chk(nm, int'(o_level), target);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            cycle();
            hi += int'(o_led);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        model_reset();
        en     = 1'b1;
        led    = 1'b0;
        resetn = 1'b0;
        #23;
        chk("rst_o_led",   int'(o_led),   0);
        chk("rst_o_busy",  int'(o_busy),  0);
        chk("rst_o_level", int'(o_level), 0);
        resetn = 1'b1;

        // Idle with input low: dark and not busy.
        count_high(1000, hi);
        chk("idle_dark", hi, 0);
        chk("idle_busy", int'(o_busy), 0);

        // Full fade up.
        led = 1'b1;
        cycle();
        chk("up_busy_1cyc", int'(o_busy), 1);
        wait_level(15, 512, "reach_max");
        chk("max_not_busy", int'(o_busy), 0);
        repeat (40) cycle();
        count_high(64, hi);
        chk("full_on", hi, 64);

        // Fade down fully, then up to 7 and reverse.
        led = 1'b0;
        wait_level(0, 600, "down_to_0");
        led = 1'b1;
        wait_level(7, 600, "up_to_7");
        led = 1'b0;
        cycle();
        chk("rev_busy", int'(o_busy), 1);
        chk("rev_hold7", int'(o_level), 7);
        wait_level(0, 256, "rev_to_0");
        chk("rev_off", int'(o_busy), 0);
        repeat (40) cycle();
        count_high(32, hi);
        chk("off_dark", hi, 0);

        // Hold level 5 by reversing direction every cycle, then measure duty.
        led = 1'b1;
        wait_level(5, 600, "up_to_5");
        repeat (64) begin
            led = ~led;
            cycle();
        end
        chk("hold5_level", int'(o_level), 5);
        hi = 0;
        repeat (32) begin
            led = ~led;
            cycle();
            hi += int'(o_led);
        end
        chk("hold5_high", hi, 2 * ref_eff(5));

        // Enable drop during UP at level 9.
        led = 1'b1;
        wait_level(9, 300, "up_to_9");
        en = 1'b0;
        cycle();
        chk("en_lvl0",  int'(o_level), 0);
        chk("en_busy0", int'(o_busy),  0);
        chk("en_led0",  int'(o_led),   0);
        en  = 1'b1;
        led = 1'b1;
        cycle();
        chk("en_restart_busy",  int'(o_busy),  1);
        chk("en_restart_level", int'(o_level), 0);

        // Randomised input/enable sequences.
        repeat (20) begin
            led = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 9) != 0);
            repeat ($urandom_range(1, 300)) cycle();
        end

        // Asynchronous reset mid-fade.
        en  = 1'b1;
        led = 1'b1;
        repeat (100) cycle();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_o_led",   int'(o_led),   0);
        chk("arst_o_busy",  int'(o_busy),  0);
        chk("arst_o_level", int'(o_level), 0);
        model_reset();
        @(posedge clk);
        #3;
        resetn = 1'b1;
        repeat (200) cycle();

`ifdef LED_BREATHE_GAMMA_EN
        chk("gamma_8",  int'(led_breathe_driver_pkg::eff(32'd8, 4)),  4);
        chk("gamma_15", int'(led_breathe_driver_pkg::eff(32'd15, 4)), 15);
        chk("gamma_3",  int'(led_breathe_driver_pkg::eff(32'd3, 4)),  0);
`endif

        @(negedge clk);
        #1;
        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
